// File: rtl/lt24_pio_pkg.sv
// Shared definitions for the LT24 pulse-capable output PIO.
//   ADDR_*      word addresses of the Avalon-MM register map
//   state enum  pulse timer states
//   STAT_*      bit positions inside the STATUS register
package lt24_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_PMASK  = 3'd3;
  localparam logic [2:0] ADDR_PCOUNT = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_IRQEN  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/lt24_pulse_timer.sv
// Pulse timer: FSM plus down-counter that holds the pulse window.
//   clk, rst    clock, async active-high reset
//   start       nonzero count write while idle
//   load        nonzero count write while pulsing (retrigger)
//   abort       zero count write while pulsing
//   load_val    count to load on start/load
//   busy        pulse window active
//   done_pulse  one-cycle strobe on natural completion
//   cnt         remaining count (0 when idle)
module lt24_pulse_timer
  import lt24_pio_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load,
  input  logic             abort,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] cnt
);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    // A count write always takes priority over completion in the same cycle.
    if (start || load) begin
      state_d = ST_PULSE;
      cnt_d   = load_val;
    end else if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_PULSE) begin
      // Leave at cnt==1 so the counter never wraps through zero.
      if (cnt_q == CNT_W'(1)) begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        done_pulse = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_PULSE);
  assign cnt  = cnt_q;

endmodule

// File: rtl/lt24_pio_pulse_out.sv
// Avalon-MM output PIO with atomic set/clear and a timed inversion pulse.
//   clk, reset          clock, async active-high reset
//   address..writedata  Avalon-MM slave (zero wait states)
//   readdata            combinational read mux
//   out_port            DATA, with PMASK bits inverted while a pulse runs
//   irq                 done & IRQEN[0]
module lt24_pio_pulse_out
  import lt24_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic             irqen_q, irqen_d;
  logic             done_q, done_d;

  logic             wr;
  logic             wr_pcount, pcount_nz;
  logic             busy, done_pulse;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] wd;

  // Reads need no strobe: readdata is valid whenever address is.
  logic unused_rd;
  assign unused_rd = ^{read_n, writedata};

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign wr_pcount = wr && (address == ADDR_PCOUNT);
  assign pcount_nz = |writedata[CNT_W-1:0];

  lt24_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .start      (wr_pcount && pcount_nz && !busy),
    .load       (wr_pcount && pcount_nz && busy),
    .abort      (wr_pcount && !pcount_nz && busy),
    .load_val   (writedata[CNT_W-1:0]),
    .busy       (busy),
    .done_pulse (done_pulse),
    .cnt        (cnt)
  );

  always_comb begin
    data_d  = data_q;
    pmask_d = pmask_q;
    irqen_d = irqen_q;
    done_d  = done_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d  = wd;
        ADDR_SET:    data_d  = data_q | wd;
        ADDR_CLEAR:  data_d  = data_q & ~wd;
        ADDR_PMASK:  pmask_d = wd;
        ADDR_STATUS: if (writedata[STAT_DONE]) done_d = 1'b0;
        ADDR_IRQEN:  irqen_d = writedata[0];
        default: ;
      endcase
    end
    // Completion overrides a W1C landing in the same cycle.
    if (done_pulse) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      pmask_q <= '0;
      irqen_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      pmask_q <= pmask_d;
      irqen_q <= irqen_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_q);
      ADDR_PMASK:  readdata = 32'(pmask_q);
      ADDR_PCOUNT: readdata = 32'(cnt);
      ADDR_STATUS: begin
        readdata[STAT_BUSY] = busy;
        readdata[STAT_DONE] = done_q;
      end
      ADDR_IRQEN:  readdata = {31'd0, irqen_q};
      default:     readdata = '0;
    endcase
  end

  assign out_port = data_q ^ (busy ? pmask_q : '0);
  assign irq      = done_q & irqen_q;

endmodule

// File: tb/tb_lt24_pio_pulse_out.sv
module tb_lt24_pio_pulse_out;

  localparam int          WIDTH = 8;
  localparam int          CNT_W = 24;
  localparam logic [7:0]  RV    = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic [7:0]  out_port;
  logic        irq;

  lt24_pio_pulse_out #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the pulse is an absolute end time in edge counts.
  int         t;       // edges since last reset release
  logic [7:0] m_data, m_pmask;
  logic       m_irqen, m_done, m_busy;
  int         m_end;
  logic [7:0] last_out;

  function automatic void m_reset();
    m_data = RV; m_pmask = 8'h00; m_irqen = 1'b0; m_done = 1'b0;
    m_busy = 1'b0; m_end = 0; t = 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return {24'd0, m_data};
      3'd3: return {24'd0, m_pmask};
      3'd4: return m_busy ? 32'(m_end - t) : 32'd0;
      3'd5: return {30'd0, m_done, m_busy};
      3'd6: return {31'd0, m_irqen};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
    logic fin;
    int   n;
    t++;
    fin = m_busy && (t == m_end);
    if (w && a == 3'd4) begin
      n = int'(d & 32'h00FF_FFFF);
      fin = 1'b0;
      if (n != 0) begin m_busy = 1'b1; m_end = t + n; end
      else m_busy = 1'b0;
    end
    if (fin) m_busy = 1'b0;
    if (w) case (a)
      3'd0: m_data = d[7:0];
      3'd1: m_data = m_data | d[7:0];
      3'd2: m_data = m_data & ~d[7:0];
      3'd3: m_pmask = d[7:0];
      3'd5: if (d[1]) m_done = 1'b0;
      3'd6: m_irqen = d[0];
      default: ;
    endcase
    if (fin) m_done = 1'b1;
  endfunction

  // One bus cycle: check the pre-edge read, clock, then check the pins.
  task automatic step(input logic cs, input logic w, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs; write_n = ~w; read_n = w; address = a; writedata = d;
    #1 chk($sformatf("rd%0d", a), readdata, m_rd(a));
    @(posedge clk);
    m_edge(cs && w, a, d);
    #1;
    chk("out_port", {24'd0, out_port}, {24'd0, m_data ^ (m_busy ? m_pmask : 8'h00)});
    chk("irq", {31'd0, irq}, {31'd0, m_done & m_irqen});
    last_out = out_port;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd5, 32'd0);
  endtask

  int lows;

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 3'd0; writedata = '0;
    m_reset();
    #2;
    chk("rst_out", {24'd0, out_port}, {24'd0, RV});
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 chk($sformatf("rst_rd%0d", a), readdata, (a < 3) ? {24'd0, RV} : 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    idle();

    // set / clear
    wr(3'd0, 32'h0F); wr(3'd1, 32'h30); wr(3'd2, 32'h03);
    chk("set_clr", {24'd0, out_port}, 32'h3C);

    // basic pulse of 5
    wr(3'd0, 32'h01); wr(3'd3, 32'h01); wr(3'd6, 32'h1);
    wr(3'd4, 32'd5);
    lows = (last_out[0] == 1'b0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin idle(); if (last_out[0] == 1'b0) lows++; end
    chk("pulse_len", 32'(lows), 32'd5);
    chk("pulse_irq", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'h2);
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // retrigger 10 then 3 after 4 cycles -> 7 cycles
    wr(3'd4, 32'd10);
    lows = 1;
    for (int i = 0; i < 3; i++) begin idle(); if (last_out[0] == 1'b0) lows++; end
    wr(3'd4, 32'd3); if (last_out[0] == 1'b0) lows++;
    for (int i = 0; i < 6; i++) begin idle(); if (last_out[0] == 1'b0) lows++; end
    chk("retrig_len", 32'(lows), 32'd7);
    wr(3'd5, 32'h2);

    // retrigger on the completion cycle, then abort mid-pulse
    wr(3'd4, 32'd2); idle(); wr(3'd4, 32'd2);
    chk("retrig_done", {31'd0, irq}, 32'd0);
    idle(); idle(); wr(3'd5, 32'h2);
    wr(3'd4, 32'd5); idle(); wr(3'd4, 32'd0);
    chk("abort_out", {24'd0, out_port}, 32'h01);
    idle(); idle(); idle(); idle(); idle();
    chk("abort_irq", {31'd0, irq}, 32'd0);

    // PCOUNT with only bits above CNT_W set is treated as zero
    wr(3'd4, 32'h0100_0000); idle();

    // W1C on completion cycle keeps done
    wr(3'd4, 32'd2); idle(); wr(3'd5, 32'h2);
    chk("w1c_race", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'h2);

    // DATA write mid-pulse
    wr(3'd4, 32'd5); wr(3'd0, 32'hF0);
    chk("data_mid", {24'd0, out_port}, 32'hF1);
    for (int i = 0; i < 6; i++) idle();

    // async reset mid-pulse
    wr(3'd4, 32'd1000); idle(); idle();
    address = 3'd5; chipselect = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_out", {24'd0, out_port}, {24'd0, RV});
    chk("async_busy", readdata, 32'd0);
    reset = 1'b0;
    m_reset();
    wr(3'd3, 32'h81); wr(3'd4, 32'd2);
    for (int i = 0; i < 4; i++) idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd4) d = {8'($urandom_range(0, 3)), 24'($urandom_range(0, 12))};
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
